irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 131 +++++++++++++
 tb/tb_irq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared FSM state type and default register map for the interrupt controller.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2
   } irq_state_e;

   localparam logic [31:0] IRQ_BASE_DEF = 32'hF000_0800;

   localparam logic [31:0] IPR_OFS = 32'h0000_0010;
   localparam logic [31:0] IMR_OFS = 32'h0000_0014;
   localparam logic [31:0] EOI_OFS = 32'h0000_0018;

   localparam logic [31:0] IPR_ADDR_DEF = IRQ_BASE_DEF + IPR_OFS;
   localparam logic [31:0] IMR_ADDR_DEF = IRQ_BASE_DEF + IMR_OFS;
   localparam logic [31:0] EOI_ADDR_DEF = IRQ_BASE_DEF + EOI_OFS;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the lowest set request index wins.
module irq_prio_enc #(
   parameter int unsigned NUM_IRQ = 4
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic [2:0]         idx_o,
   output logic               valid_o
);

   // Scan downwards so the last hit, and thus the result, is the lowest index.
   always_comb begin
      idx_o   = 3'd0;
      valid_o = 1'b0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = 3'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with pending/mask registers and an IDLE/REQ/SVC handshake.
// Define IRQ_CTRL_EDGE_EN for rising-edge source events; the default build is level-sensitive.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned     BITS     = 32,
   parameter int unsigned     NUM_IRQ  = 4,
   parameter logic [BITS-1:0] IPR_BASE = BITS'(IPR_ADDR_DEF),
   parameter logic [BITS-1:0] IMR_BASE = BITS'(IMR_ADDR_DEF),
   parameter logic [BITS-1:0] EOI_BASE = BITS'(EOI_ADDR_DEF)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [BITS-1:0]    memAddr,
   input  logic [BITS-1:0]    dataBusIn,
   output logic [BITS-1:0]    dataBusOut,
   input  logic [NUM_IRQ-1:0] irqIn,
   output logic               intrReq,
   input  logic               intrAck,
   output logic [2:0]         intrVec
);

   irq_state_e         state_q, state_d;
   logic [2:0]         vec_q, vec_d;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] insvc_q, insvc_d;
   logic [NUM_IRQ-1:0] evt, eligible, vec_oh, pend_clr;
   logic [2:0]         enc_idx;
   logic               enc_valid, lat_elig;
   logic               ipr_wr, imr_wr, eoi_wr;
   logic               unused_data;

   assign ipr_wr      = we && (memAddr == IPR_BASE);
   assign imr_wr      = we && (memAddr == IMR_BASE);
   assign eoi_wr      = we && (memAddr == EOI_BASE);
   assign unused_data = ^dataBusIn;

`ifdef IRQ_CTRL_EDGE_EN
   logic [NUM_IRQ-1:0] hist_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) hist_q <= '0;
      else       hist_q <= irq_q;
   end

   assign evt = irq_q & ~hist_q;
`else
   assign evt = irq_q;
`endif

   assign eligible = pend_q & mask_q & ~insvc_q;
   assign vec_oh   = NUM_IRQ'(1) << vec_q;
   assign lat_elig = |(eligible & vec_oh);

   irq_prio_enc #(
      .NUM_IRQ(NUM_IRQ)
   ) u_prio_enc (
      .req_i  (eligible),
      .idx_o  (enc_idx),
      .valid_o(enc_valid)
   );

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      insvc_d  = insvc_q;
      pend_clr = ipr_wr ? dataBusIn[NUM_IRQ-1:0] : '0;
      case (state_q)
         IDLE: begin
            if (enc_valid) begin
               state_d = REQ;
               vec_d   = enc_idx;
            end
         end
         REQ: begin
            // Ack wins over the latched source losing eligibility in the same cycle.
            if (intrAck) begin
               state_d  = SVC;
               pend_clr = pend_clr | vec_oh;
               insvc_d  = insvc_q | vec_oh;
            end else if (!lat_elig) begin
               state_d = IDLE;
            end
         end
         SVC: begin
            if (eoi_wr) begin
               state_d = IDLE;
               insvc_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // A new event always beats any clear in the same cycle.
      pend_d = (pend_q & ~pend_clr) | evt;
      mask_d = imr_wr ? dataBusIn[NUM_IRQ-1:0] : mask_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= 3'd0;
         irq_q   <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         insvc_q <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         irq_q   <= irqIn;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         insvc_q <= insvc_d;
      end
   end

   always_comb begin
      dataBusOut = '0;
      if (re && !we) begin
         if (memAddr == IPR_BASE)      dataBusOut = BITS'(pend_q);
         else if (memAddr == IMR_BASE) dataBusOut = BITS'(mask_q);
      end
   end

   assign intrReq = (state_q == REQ);
   assign intrVec = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_irq_ctrl;

   localparam logic [31:0] IPR_A = 32'hF000_0810;
   localparam logic [31:0] IMR_A = 32'hF000_0814;
   localparam logic [31:0] EOI_A = 32'hF000_0818;

   logic        clk, reset, we, re, intrAck, intrReq;
   logic [31:0] memAddr, dataBusIn, dataBusOut;
   logic [3:0]  irqIn;
   logic [2:0]  intrVec;

   typedef struct {
      bit          rst, we, re, ack;
      logic [31:0] addr, din;
      bit   [3:0]  irq;
   } stim_t;

   typedef struct {
      bit          req;
      bit          chk_vec;
      bit   [2:0]  vec;
      logic [31:0] dout;
   } exp_t;

   exp_t expq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: pipeline of sampled lines, register contents, and the open interrupt.
   bit [3:0] m_line, m_hist, m_pend, m_mask, m_insvc;
   int       m_phase;  // 0: nothing outstanding, 1: requesting CPU, 2: CPU servicing
   int       m_vec;

   irq_ctrl #(
      .BITS   (32),
      .NUM_IRQ(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .re        (re),
      .memAddr   (memAddr),
      .dataBusIn (dataBusIn),
      .dataBusOut(dataBusOut),
      .irqIn     (irqIn),
      .intrReq   (intrReq),
      .intrAck   (intrAck),
      .intrVec   (intrVec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_clear();
      m_line  = '0;
      m_hist  = '0;
      m_pend  = '0;
      m_mask  = '0;
      m_insvc = '0;
      m_phase = 0;
      m_vec   = 0;
   endtask

   task automatic model_edge(input stim_t s);
      bit [3:0] ev, elig, clr;
      int       low;
`ifdef IRQ_CTRL_EDGE_EN
      ev = m_line & ~m_hist;
`else
      ev = m_line;
`endif
      elig = m_pend & m_mask & ~m_insvc;
      low  = -1;
      for (int i = 0; i < 4; i++) if (elig[i] && low < 0) low = i;
      clr = (s.we && s.addr == IPR_A) ? s.din[3:0] : 4'b0;
      if (m_phase == 0) begin
         if (low >= 0) begin
            m_phase = 1;
            m_vec   = low;
         end
      end else if (m_phase == 1) begin
         if (s.ack) begin
            m_phase        = 2;
            clr[m_vec]     = 1'b1;
            m_insvc[m_vec] = 1'b1;
         end else if (!elig[m_vec]) begin
            m_phase = 0;
         end
      end else if (s.we && s.addr == EOI_A) begin
         m_phase = 0;
         m_insvc = '0;
      end
      m_pend = (m_pend & ~clr) | ev;
      if (s.we && s.addr == IMR_A) m_mask = s.din[3:0];
      m_hist = m_line;
      m_line = s.irq;
   endtask

   // Drive one cycle of inputs, queue what the outputs must show during it, then cross the edge.
   task automatic step(input stim_t s);
      exp_t e;
      reset     = s.rst;
      we        = s.we;
      re        = s.re;
      memAddr   = s.addr;
      dataBusIn = s.din;
      irqIn     = s.irq;
      intrAck   = s.ack;
      if (s.rst) model_clear();
      e.req     = (m_phase == 1);
      e.chk_vec = (m_phase == 1) || s.rst;
      e.vec     = 3'(m_vec);
      e.dout    = 32'h0;
      if (s.re && !s.we) begin
         if (s.addr == IPR_A)      e.dout = {28'h0, m_pend};
         else if (s.addr == IMR_A) e.dout = {28'h0, m_mask};
      end
      expq.push_back(e);
      @(posedge clk);
      if (s.rst) model_clear();
      else       model_edge(s);
      #1;
   endtask

   task automatic drv(input bit rst, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input bit [3:0] irq, input bit ack);
      stim_t s;
      s.rst  = rst;
      s.we   = w;
      s.re   = r;
      s.addr = a;
      s.din  = d;
      s.irq  = irq;
      s.ack  = ack;
      step(s);
   endtask

   task automatic idle(input int n, input bit [3:0] irq);
      for (int i = 0; i < n; i++) drv(0, 0, 1, IPR_A, 32'h0, irq, 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            n_vec++;
            if (intrReq !== e.req) begin
               n_bad++;
               $display("FAIL intrReq @%0t: got %b, expected %b", $time, intrReq, e.req);
            end
            if (e.chk_vec && intrVec !== e.vec) begin
               n_bad++;
               $display("FAIL intrVec @%0t: got %0d, expected %0d", $time, intrVec, e.vec);
            end
            if (dataBusOut !== e.dout) begin
               n_bad++;
               $display("FAIL dataBusOut @%0t: got %h, expected %h", $time, dataBusOut, e.dout);
            end
         end
      end
   end

   initial begin
      stim_t    s;
      bit [3:0] line;
      model_clear();
      reset = 1'b1; we = 0; re = 0; intrAck = 0;
      memAddr = '0; dataBusIn = '0; irqIn = '0;
      @(posedge clk);
      #1;
      drv(1, 0, 1, IPR_A, 0, 4'h0, 0);
      drv(1, 0, 1, IMR_A, 0, 4'h0, 0);
      idle(2, 4'h0);

      // Single source: request, ack, pending clear, EOI.
      drv(0, 1, 0, IMR_A, 32'h1, 4'h0, 0);
      drv(0, 0, 0, 0, 0, 4'h1, 0);
      idle(3, 4'h0);
      drv(0, 0, 1, IMR_A, 0, 4'h0, 1);
      idle(2, 4'h0);
      drv(0, 1, 0, EOI_A, 32'hDEAD, 4'h0, 0);
      idle(2, 4'h0);

      // Two sources together: lowest index first, then the other after EOI.
      drv(0, 1, 0, IMR_A, 32'hF, 4'h0, 0);
      drv(0, 0, 0, 0, 0, 4'hA, 0);
      idle(3, 4'h0);
      drv(0, 0, 0, 0, 0, 4'h0, 1);
      idle(1, 4'h0);
      drv(0, 1, 0, EOI_A, 0, 4'h0, 0);
      idle(3, 4'h0);
      drv(0, 0, 0, 0, 0, 4'h0, 1);
      drv(0, 1, 0, EOI_A, 0, 4'h0, 0);

      // Masked source stays pending until unmasked.
      drv(0, 1, 0, IMR_A, 32'h0, 4'h0, 0);
      drv(0, 0, 0, 0, 0, 4'h4, 0);
      idle(3, 4'h0);
      drv(0, 1, 0, IMR_A, 32'h4, 4'h0, 0);
      idle(2, 4'h0);
      drv(0, 0, 0, 0, 0, 4'h0, 1);
      drv(0, 1, 0, EOI_A, 0, 4'h0, 0);

      // W1C of the latched source without ack, then coincident with ack.
      drv(0, 1, 0, IMR_A, 32'h1, 4'h0, 0);
      drv(0, 0, 0, 0, 0, 4'h1, 0);
      idle(3, 4'h0);
      drv(0, 1, 0, IPR_A, 32'h1, 4'h0, 0);
      idle(2, 4'h0);
      drv(0, 0, 0, 0, 0, 4'h1, 0);
      idle(3, 4'h0);
      drv(0, 1, 0, IPR_A, 32'h1, 4'h0, 1);
      idle(1, 4'h0);

      // Asynchronous reset while servicing, then no request without a fresh event.
      drv(1, 0, 1, IMR_A, 0, 4'h0, 0);
      drv(0, 1, 0, IMR_A, 32'hF, 4'h0, 0);
      idle(4, 4'h0);

      // Held line through ack and W1C: edge build stays quiet, level build re-requests.
      drv(0, 1, 0, IMR_A, 32'h2, 4'h2, 0);
      idle(3, 4'h2);
      drv(0, 0, 0, 0, 0, 4'h2, 1);
      drv(0, 1, 0, IPR_A, 32'h2, 4'h2, 0);
      idle(2, 4'h2);
      drv(0, 1, 0, EOI_A, 0, 4'h2, 0);
      idle(3, 4'h2);
      drv(0, 0, 0, 0, 0, 4'h0, 1);
      drv(0, 1, 0, EOI_A, 0, 4'h0, 0);
      idle(3, 4'h0);

      // Random traffic.
      line = '0;
      for (int n = 0; n < 3000; n++) begin
         s.rst = ($urandom_range(0, 249) == 0);
         s.we  = ($urandom_range(0, 3) == 0);
         s.re  = ($urandom_range(0, 2) == 0);
         s.ack = ($urandom_range(0, 2) == 0);
         s.din = $urandom;
         case ($urandom_range(0, 4))
            0:       s.addr = IPR_A;
            1:       s.addr = IMR_A;
            2:       s.addr = EOI_A;
            3:       s.addr = 32'hF000_081C;
            default: s.addr = $urandom;
         endcase
         if ($urandom_range(0, 1) == 0) begin
            for (int b = 0; b < 4; b++) line[b] = ($urandom_range(0, 5) == 0);
         end
         s.irq = line;
         step(s);
      end
      idle(3, 4'h0);

      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
